// File: rtl/packet_injector.sv
// Packet injector: turns a request plus a payload stream into header/size/payload flits.
// Optional INJ_SRC_STAMP_EN inserts the local address as the first payload flit.
`timescale 1ns/1ps
module packet_injector #(
    parameter int                  TAM_FLIT = 16,
    parameter logic [TAM_FLIT-1:0] adress   = TAM_FLIT'(16)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [TAM_FLIT-1:0] req_dest,
    input  logic [TAM_FLIT-1:0] req_size,
    input  logic                pl_valid,
    output logic                pl_ready,
    input  logic [TAM_FLIT-1:0] pl_data,
    output logic                tx,
    output logic [TAM_FLIT-1:0] data_out,
    input  logic                credit_i,
    output logic                busy,
    output logic                pkt_sent
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_SIZE,
        S_PAYLOAD,
        S_DRAIN
    } state_t;

    localparam logic [TAM_FLIT-1:0] ONE = TAM_FLIT'(1);

`ifdef INJ_SRC_STAMP_EN
    localparam bit STAMP_EN = 1'b1;
`else
    localparam bit STAMP_EN = 1'b0;
`endif

    state_t              r_state;
    state_t              w_next;
    logic                r_tx;
    logic [TAM_FLIT-1:0] r_data;
    logic [TAM_FLIT-1:0] r_dest;
    logic [TAM_FLIT-1:0] r_size;
    logic [TAM_FLIT-1:0] r_remaining;
    logic                r_stamp;
    logic                r_pkt_sent;

    logic                w_can_load;
    logic                w_req_ready;
    logic                w_pl_ready;
    logic                w_busy;
    logic                w_req_fire;
    logic                w_pl_fire;
    logic                w_size_all1;
    logic                w_size_zero;
    logic [TAM_FLIT-1:0] w_user_cnt;
    logic [TAM_FLIT-1:0] w_size_flit;

    // The output register may take a new flit only when it is empty or draining now.
    assign w_can_load  = !r_tx || credit_i;
    assign w_req_fire  = req_valid && w_req_ready;
    assign w_pl_fire   = pl_valid && w_pl_ready;

    // With the stamp, an all-ones request is clamped so the size flit cannot wrap.
    assign w_size_all1 = &r_size;
    assign w_user_cnt  = (STAMP_EN && w_size_all1) ? r_size - ONE : r_size;
    assign w_size_flit = STAMP_EN ? (w_size_all1 ? r_size : r_size + ONE)
                                  : r_size;
    assign w_size_zero = !STAMP_EN && (r_size == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_req_fire) w_next = S_HEADER;
            end
            S_HEADER: begin
                if (w_can_load) w_next = S_SIZE;
            end
            S_SIZE: begin
                if (w_can_load) w_next = w_size_zero ? S_DRAIN : S_PAYLOAD;
            end
            S_PAYLOAD: begin
                if (r_stamp) begin
                    if (w_can_load && r_remaining == '0) w_next = S_DRAIN;
                end else if (w_pl_fire && r_remaining == ONE) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_tx && credit_i) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_req_ready = 1'b0;
        w_pl_ready  = 1'b0;
        w_busy      = (r_state != S_IDLE) || r_tx;
        if (!reset) begin
            w_req_ready = (r_state == S_IDLE) && w_can_load;
            w_pl_ready  = (r_state == S_PAYLOAD) && w_can_load
                          && !r_stamp && (r_remaining != '0);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tx        <= 1'b0;
            r_data      <= '0;
            r_dest      <= '0;
            r_size      <= '0;
            r_remaining <= '0;
            r_stamp     <= 1'b0;
            r_pkt_sent  <= 1'b0;
        end else begin
            r_pkt_sent <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_req_fire) begin
                        r_dest <= req_dest;
                        r_size <= req_size;
                    end
                end
                S_HEADER: begin
                    if (w_can_load) begin
                        r_data <= r_dest;
                        r_tx   <= 1'b1;
                    end
                end
                S_SIZE: begin
                    if (w_can_load) begin
                        r_data      <= w_size_flit;
                        r_tx        <= 1'b1;
                        r_remaining <= w_user_cnt;
                        r_stamp     <= STAMP_EN;
                    end
                end
                S_PAYLOAD: begin
                    if (r_stamp) begin
                        if (w_can_load) begin
                            r_data  <= adress;
                            r_tx    <= 1'b1;
                            r_stamp <= 1'b0;
                        end
                    end else if (w_pl_fire) begin
                        r_data      <= pl_data;
                        r_tx        <= 1'b1;
                        r_remaining <= r_remaining - ONE;
                    end else if (w_can_load) begin
                        // Held flit left (or none held): go quiet, never a bubble.
                        r_tx <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (r_tx && credit_i) begin
                        r_tx       <= 1'b0;
                        r_pkt_sent <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = w_req_ready;
    assign pl_ready  = w_pl_ready;
    assign tx        = r_tx;
    assign data_out  = r_data;
    assign busy      = w_busy;
    assign pkt_sent  = r_pkt_sent;

endmodule

// File: tb/tb_packet_injector.sv
// Self-checking bench for packet_injector: flit-queue model plus directed packets.
// Works with or without INJ_SRC_STAMP_EN defined.
`timescale 1ns/1ps
module tb_packet_injector;

    localparam logic [15:0] ADR = 16'h0101;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_dest = '0;
    logic [15:0] req_size = '0;
    logic        pl_valid = 1'b0;
    logic        pl_ready;
    logic [15:0] pl_data = '0;
    logic        tx;
    logic [15:0] data_out;
    logic        credit_i;
    logic        busy;
    logic        pkt_sent;

    packet_injector #(.TAM_FLIT(16), .adress(ADR)) dut (
        .clock    (clock),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_dest (req_dest),
        .req_size (req_size),
        .pl_valid (pl_valid),
        .pl_ready (pl_ready),
        .pl_data  (pl_data),
        .tx       (tx),
        .data_out (data_out),
        .credit_i (credit_i),
        .busy     (busy),
        .pkt_sent (pkt_sent)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] d;
        bit          last;
    } flit_t;

    flit_t       exp_q[$];
    logic [15:0] log_q[$];
    int          xfer_cyc[$];
    logic [15:0] pl_buf[$];
    logic [15:0] lit[8];
    int          n_lit;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc = 0;
    bit exp_pulse = 0;
    int pulses = 0;
    int plr_seen = 0;
    int txlow_seen = 0;
    int hdr_hold = 0;
    bit arm = 0;
    int stall_left = 0;
    logic [15:0] arm_hdr = '0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] sz_flit(logic [15:0] s);
`ifdef INJ_SRC_STAMP_EN
        return (s == 16'hFFFF) ? 16'hFFFF : s + 16'd1;
`else
        return s;
`endif
    endfunction

    // Model: the whole packet as the router must see it, in order.
    task automatic model_pkt(logic [15:0] dest, logic [15:0] size);
        flit_t f[$];
        flit_t t;
        t.last = 0;
        t.d = dest;
        f.push_back(t);
        t.d = sz_flit(size);
        f.push_back(t);
`ifdef INJ_SRC_STAMP_EN
        t.d = ADR;
        f.push_back(t);
`endif
        foreach (pl_buf[i]) begin
            t.d = pl_buf[i];
            f.push_back(t);
        end
        f[f.size()-1].last = 1;
        foreach (f[i]) exp_q.push_back(f[i]);
    endtask

    always @(posedge clock) cyc++;

    initial begin
        credit_i = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (arm && tx && data_out == arm_hdr) begin
                arm = 0;
                credit_i = 1'b0;
                stall_left = 2;
            end else if (stall_left > 0) begin
                credit_i = 1'b0;
                stall_left--;
            end else begin
                credit_i = 1'b1;
            end
        end
    end

    initial begin
        flit_t f;
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_pulse = 0;
                continue;
            end
            chk("pkt_sent", pkt_sent, exp_pulse);
            if (pkt_sent) pulses++;
            if (pl_ready) plr_seen++;
            if (!tx && busy) txlow_seen++;
            if (tx && data_out == 16'h0201) hdr_hold++;
            exp_pulse = 0;
            if (tx && credit_i) begin
                log_q.push_back(data_out);
                xfer_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_flit: got %h, none expected", data_out);
                end else begin
                    f = exp_q.pop_front();
                    chk("flit", data_out, f.d);
                    exp_pulse = f.last;
                end
            end
        end
    end

    task automatic send_req(logic [15:0] dest, logic [15:0] size);
        bit got = 0;
        int n = 0;
        req_dest = dest;
        req_size = size;
        req_valid = 1'b1;
        while (!got && n < 50) begin
            @(negedge clock);
            got = req_ready;
            if (got) acc_cyc = cyc;
            @(posedge clock);
            #1;
            n++;
        end
        req_valid = 1'b0;
        if (!got) chk("req_timeout", 0, 1);
    endtask

    task automatic feed(int gap_after);
        foreach (pl_buf[i]) begin
            bit got = 0;
            int n = 0;
            pl_valid = 1'b1;
            pl_data = pl_buf[i];
            while (!got && n < 50) begin
                @(negedge clock);
                got = pl_ready;
                @(posedge clock);
                #1;
                n++;
            end
            pl_valid = 1'b0;
            if (!got) chk("pl_timeout", 0, 1);
            if (i == gap_after) begin
                repeat (2) @(posedge clock);
                #1;
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (n >= 300) chk("idle_timeout", 0, 1);
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic send_pkt(logic [15:0] dest, logic [15:0] size, int gap);
        log_q.delete();
        xfer_cyc.delete();
        model_pkt(dest, size);
        send_req(dest, size);
        feed(gap);
        wait_idle();
    endtask

    task automatic chk_lit(string name);
        chk({name, "_len"}, log_q.size(), n_lit);
        for (int i = 0; i < n_lit; i++) chk(name, log_q[i], lit[i]);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_tx", tx, 0);
        chk("rst_data", data_out, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_pl_ready", pl_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pkt_sent", pkt_sent, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("req_ready_after_rst", req_ready, 1);
        @(posedge clock);
        #1;

        // Basic packet at full rate.
        pulses = 0;
        pl_buf = '{16'h00A1, 16'h00A2};
        send_pkt(16'h0201, 16'd2, -1);
`ifdef INJ_SRC_STAMP_EN
        lit[0:4] = '{16'h0201, 16'h0003, 16'h0101, 16'h00A1, 16'h00A2};
        n_lit = 5;
`else
        lit[0:3] = '{16'h0201, 16'h0002, 16'h00A1, 16'h00A2};
        n_lit = 4;
`endif
        chk_lit("basic");
        chk("basic_hdr_latency", xfer_cyc[0] - acc_cyc, 2);
        chk("basic_back2back", xfer_cyc[n_lit-1] - xfer_cyc[0], n_lit - 1);
        chk("basic_pulses", pulses, 1);

        // Header stalled by 3 cycles of no credit.
        hdr_hold = 0;
        arm_hdr = 16'h0201;
        arm = 1;
        send_pkt(16'h0201, 16'd2, -1);
        chk_lit("stall");
        chk("stall_hdr_hold", hdr_hold, 4);

        // Zero-length payload.
        plr_seen = 0;
        pl_buf.delete();
        send_pkt(16'h0305, 16'd0, -1);
`ifdef INJ_SRC_STAMP_EN
        lit[0:2] = '{16'h0305, 16'h0001, 16'h0101};
        n_lit = 3;
`else
        lit[0:1] = '{16'h0305, 16'h0000};
        n_lit = 2;
`endif
        chk_lit("zero");
        chk("zero_pl_ready", plr_seen, 0);

        // Payload source stalls mid-packet.
        txlow_seen = 0;
        pl_buf = '{16'h00C1, 16'h00C2, 16'h00C3, 16'h00C4};
        send_pkt(16'h0102, 16'd4, 1);
`ifdef INJ_SRC_STAMP_EN
        n_lit = 7;
`else
        n_lit = 6;
`endif
        chk("gap_len", log_q.size(), n_lit);
        chk("gap_tx_dropped", txlow_seen > 0, 1);
        chk("gap_last", log_q[n_lit-1], 16'h00C4);

        // Destination equal to the local address.
        pl_buf = '{16'h00D1};
        send_pkt(ADR, 16'd1, -1);
        chk("self_hdr", log_q[0], ADR);

        // Reset while the size flit of a 4-flit packet is on the output.
        log_q.delete();
        pl_buf = '{16'h00E1, 16'h00E2};
        model_pkt(16'h0404, 16'd2);
        send_req(16'h0404, 16'd2);
        n = 0;
        while (!(tx && data_out == sz_flit(16'd2)) && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) chk("size_wait_timeout", 0, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_tx", tx, 0);
        chk("midrst_data", data_out, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_req_ready", req_ready, 0);
        chk("midrst_pl_ready", pl_ready, 0);
        chk("midrst_pkt_sent", pkt_sent, 0);
        exp_q.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_req_ready_after", req_ready, 1);
        @(posedge clock);
        #1;
        pl_buf = '{16'h00F1};
        send_pkt(16'h0505, 16'd1, -1);
        chk("fresh_hdr", log_q[0], 16'h0505);
        chk("fresh_size", log_q[1], sz_flit(16'd1));
        chk("fresh_last", log_q[log_q.size()-1], 16'h00F1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/packet_injector.md
PACKET_INJECTOR -- requirements
Module: packet_injector

Interface
REQ-001 Parameter adress, default 16, is the local router address: X in bits [TAM_FLIT-1:METADEFLIT], Y in [METADEFLIT-1:0].
REQ-002 clock  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  packet request present.
REQ-005 req_ready  output  1  request accepted when req_valid && req_ready.
REQ-006 req_dest  input  TAM_FLIT  destination address, same X/Y layout as adress.
REQ-007 req_size  input  TAM_FLIT  user payload flit count.
REQ-008 pl_valid  input  1  payload flit present.
REQ-009 pl_ready  output  1  payload flit consumed when pl_valid && pl_ready.
REQ-010 pl_data  input  TAM_FLIT  payload flit.
REQ-011 tx  output  1  data_out holds a valid flit toward the router local input port.
REQ-012 data_out  output  TAM_FLIT  flit to router.
REQ-013 credit_i  input  1  router buffer has space; a flit transfers on any edge with tx && credit_i.
REQ-014 busy  output  1  packet in progress (state != IDLE, or tx high).
REQ-015 pkt_sent  output  1  one-cycle pulse on the edge the last flit of a packet transfers.

Function
REQ-016 Packet format: flit 0 = header (req_dest verbatim), flit 1 = size (payload count), then that many payload flits; header is the flit the router's XY routing logic decodes.
REQ-017 FSM states: IDLE, HEADER, SIZE, PAYLOAD, DRAIN.
REQ-018 Output register rule: tx/data_out load a new flit only on an edge where !tx || credit_i; otherwise hold unchanged (no flit lost or duplicated under backpressure).
REQ-019 IDLE: req_ready = !tx || credit_i; on request accept, latch dest and size, go HEADER.
REQ-020 HEADER: when the output register can load, load header, set tx, go SIZE.
REQ-021 SIZE: when the output register can load, load size flit, go PAYLOAD, or DRAIN when the count is 0.
REQ-022 PAYLOAD: pl_ready = (output register can load) && remaining > 0; each accepted pl_data loads data_out, decrements remaining; after the last accepted flit go DRAIN.
REQ-023 PAYLOAD with pl_valid low: tx clears once the held flit transfers; no bubble flit is emitted.
REQ-024 DRAIN: wait until the last flit transfers (tx && credit_i), clear tx, pulse pkt_sent, return IDLE; a new request is not accepted in that same cycle.
REQ-025 Best-case throughput: one flit per cycle with credit_i held high; header appears on data_out 2 cycles after request accept.
REQ-026 req_size = 0 is legal: the packet is header plus size flit 16'h0000 only.
REQ-027 Remaining-count arithmetic is TAM_FLIT-bit unsigned; it never wraps below 0.
REQ-028 Destination equal to adress is legal and injected normally.

Reset
REQ-029 Reset asserted at any time, including mid-packet, forces state IDLE, tx=0, data_out=0, pkt_sent=0, remaining=0, req_ready=0, pl_ready=0, busy=0 immediately (asynchronously).
REQ-030 After reset deasserts, req_ready rises in the first cycle; a partially sent packet is abandoned and never resumed.

Configuration
REQ-031 Macro INJ_SRC_STAMP_EN defined: the first payload flit is adress, inserted by the block without consuming pl_data; the size flit carries req_size+1; req_size 16'hFFFF is clamped to 16'hFFFE user flits (size flit 16'hFFFF).
REQ-032 INJ_SRC_STAMP_EN undefined: no stamp flit; the size flit equals req_size; all 16'hFFFF values are legal.

Verification
REQ-033 Reset, then req_dest=16'h0201, req_size=2, payload A1,A2, credit_i=1 -> data_out sequence 0201,0002,00A1,00A2 on consecutive cycles; pkt_sent pulses once.
REQ-034 Same packet with credit_i low for 3 cycles after the header -> header held steady with tx=1 for 4 cycles; no flit lost or duplicated.
REQ-035 req_size=0 -> exactly 2 flits (dest, 0000); pl_ready never asserts.
REQ-036 Reset asserted after the size flit of a 4-flit packet -> tx=0 immediately; the next packet starts with a fresh header.
REQ-037 INJ_SRC_STAMP_EN, adress=16'h0101, req_size=1, payload B1 -> flits dest,0002,0101,00B1.
REQ-038 pl_valid low for 2 cycles mid-payload -> tx drops after the pending flit transfers; flits resume with no bubble flit emitted.
